// File: rtl/alu_arbiter_if.sv
`default_nettype none
//==============================================================================
// alu_arbiter_if: requester, response and ALU-drive bundle for alu_arbiter
// Revision: 1.0
//==============================================================================
interface alu_arbiter_if #(
   parameter int WIDTH = 16,
   parameter int OPW   = 8
);
   logic             req0_valid;
   logic             req0_ready;
   logic [WIDTH-1:0] req0_a;
   logic [WIDTH-1:0] req0_b;
   logic [OPW-1:0]   req0_op;
   logic             req0_cf;

   logic             req1_valid;
   logic             req1_ready;
   logic [WIDTH-1:0] req1_a;
   logic [WIDTH-1:0] req1_b;
   logic [OPW-1:0]   req1_op;
   logic             req1_cf;

   logic             rsp0_valid;
   logic             rsp0_ready;
   logic [WIDTH-1:0] rsp0_acc;
   logic [WIDTH-1:0] rsp0_c;
   logic             rsp0_cf;
   logic             rsp0_zf;
   logic             rsp0_of;
   logic             rsp0_err;

   logic             rsp1_valid;
   logic             rsp1_ready;
   logic [WIDTH-1:0] rsp1_acc;
   logic [WIDTH-1:0] rsp1_c;
   logic             rsp1_cf;
   logic             rsp1_zf;
   logic             rsp1_of;
   logic             rsp1_err;

   logic [WIDTH-1:0] alu_a;
   logic [WIDTH-1:0] alu_b;
   logic [OPW-1:0]   alu_op;
   logic             alu_cf;
   logic [WIDTH-1:0] alu_acc;
   logic [WIDTH-1:0] alu_c;
   logic             alu_c_flag;
   logic             alu_z_flag;
   logic             alu_o_flag;

   // Arbiter side
   modport slave (
      input  req0_valid, req0_a, req0_b, req0_op, req0_cf,
      output req0_ready,
      input  req1_valid, req1_a, req1_b, req1_op, req1_cf,
      output req1_ready,
      input  rsp0_ready,
      output rsp0_valid, rsp0_acc, rsp0_c, rsp0_cf, rsp0_zf, rsp0_of, rsp0_err,
      input  rsp1_ready,
      output rsp1_valid, rsp1_acc, rsp1_c, rsp1_cf, rsp1_zf, rsp1_of, rsp1_err,
      output alu_a, alu_b, alu_op, alu_cf,
      input  alu_acc, alu_c, alu_c_flag, alu_z_flag, alu_o_flag
   );

   // Requester and ALU side
   modport master (
      output req0_valid, req0_a, req0_b, req0_op, req0_cf,
      input  req0_ready,
      output req1_valid, req1_a, req1_b, req1_op, req1_cf,
      input  req1_ready,
      output rsp0_ready,
      input  rsp0_valid, rsp0_acc, rsp0_c, rsp0_cf, rsp0_zf, rsp0_of, rsp0_err,
      output rsp1_ready,
      input  rsp1_valid, rsp1_acc, rsp1_c, rsp1_cf, rsp1_zf, rsp1_of, rsp1_err,
      input  alu_a, alu_b, alu_op, alu_cf,
      output alu_acc, alu_c, alu_c_flag, alu_z_flag, alu_o_flag
   );
endinterface
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
//==============================================================================
// alu_arbiter: round-robin sharing of one registered ALU between two requesters
// Revision: 1.0
//==============================================================================
module alu_arbiter #(
   parameter int WIDTH    = 16,
   parameter int OPW      = 8,
   parameter int LAT      = 1,
   parameter int LAT_LONG = 1
) (
   input wire           clk,
   input wire           reset,
   alu_arbiter_if.slave bus
);
   localparam int CNT_MAX = (LAT > LAT_LONG) ? LAT : LAT_LONG;
   localparam int CW      = $clog2(CNT_MAX + 1);

   localparam logic [CW-1:0]  CNT_LAT   = CW'(LAT);
   localparam logic [CW-1:0]  CNT_LONG  = CW'(LAT_LONG);
   localparam logic [OPW-1:0] OP_FIRST  = OPW'(8'h01);
   localparam logic [OPW-1:0] OP_LAST   = OPW'(8'h11);
   localparam logic [OPW-1:0] OP_MUL8   = OPW'(8'h05);
   localparam logic [OPW-1:0] OP_DIV6   = OPW'(8'h08);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t state;
   state_t state_nx;

   logic                  last_grant;
   logic                  gsel;
   logic [CW-1:0]         counter;

   logic [1:0]            req_valid;
   logic [1:0]            rsp_ready;
   logic                  grant_idx;
   logic                  accept;
   logic [WIDTH-1:0]      sel_a;
   logic [WIDTH-1:0]      sel_b;
   logic [OPW-1:0]        sel_op;
   logic                  sel_cf;
   logic                  op_legal;
   logic                  op_long;

   logic [WIDTH-1:0]      drv_a;
   logic [WIDTH-1:0]      drv_b;
   logic [OPW-1:0]        drv_op;
   logic                  drv_cf;

   logic [1:0]            rsp_valid;
   logic [1:0]            rsp_err;
   logic [1:0]            rsp_cf;
   logic [1:0]            rsp_zf;
   logic [1:0]            rsp_of;
   logic [1:0][WIDTH-1:0] rsp_acc;
   logic [1:0][WIDTH-1:0] rsp_c;

   // Arbitration: a lone requester wins outright, a tie goes to the port
   // that did not win last time.
   always_comb begin
      req_valid = {bus.req1_valid, bus.req0_valid};
      rsp_ready = {bus.rsp1_ready, bus.rsp0_ready};
      grant_idx = (req_valid == 2'b11) ? ~last_grant : req_valid[1];
      accept    = (state == IDLE) && (req_valid != 2'b00);
      sel_a     = grant_idx ? bus.req1_a  : bus.req0_a;
      sel_b     = grant_idx ? bus.req1_b  : bus.req0_b;
      sel_op    = grant_idx ? bus.req1_op : bus.req0_op;
      sel_cf    = grant_idx ? bus.req1_cf : bus.req0_cf;
      op_legal  = (sel_op >= OP_FIRST) && (sel_op <= OP_LAST);
      op_long   = (sel_op >= OP_MUL8) && (sel_op <= OP_DIV6);
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE: begin
            if (accept) begin
               state_nx = op_legal ? WAIT : DONE;
            end
         end
         WAIT: begin
            if (counter == '0) begin
               state_nx = DONE;
            end
         end
         DONE: begin
            if (rsp_ready[gsel]) begin
               state_nx = IDLE;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         last_grant <= 1'b1;
         gsel       <= 1'b0;
         counter    <= '0;
         drv_a      <= '0;
         drv_b      <= '0;
         drv_op     <= '0;
         drv_cf     <= 1'b0;
         rsp_valid  <= '0;
         rsp_err    <= '0;
         rsp_cf     <= '0;
         rsp_zf     <= '0;
         rsp_of     <= '0;
         rsp_acc    <= '0;
         rsp_c      <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  gsel       <= grant_idx;
                  last_grant <= grant_idx;
                  if (op_legal) begin
                     drv_a   <= sel_a;
                     drv_b   <= sel_b;
                     drv_op  <= sel_op;
                     drv_cf  <= sel_cf;
                     counter <= op_long ? CNT_LONG : CNT_LAT;
                  end else begin
                     // Illegal op never reaches the ALU; answer with a zeroed error response.
                     rsp_acc[grant_idx]   <= '0;
                     rsp_c[grant_idx]     <= '0;
                     rsp_cf[grant_idx]    <= 1'b0;
                     rsp_zf[grant_idx]    <= 1'b0;
                     rsp_of[grant_idx]    <= 1'b0;
                     rsp_err[grant_idx]   <= 1'b1;
                     rsp_valid[grant_idx] <= 1'b1;
                  end
               end
            end
            WAIT: begin
               if (counter == '0) begin
                  rsp_acc[gsel]   <= bus.alu_acc;
                  rsp_c[gsel]     <= bus.alu_c;
                  rsp_cf[gsel]    <= bus.alu_c_flag;
                  rsp_zf[gsel]    <= bus.alu_z_flag;
                  rsp_of[gsel]    <= bus.alu_o_flag;
                  rsp_err[gsel]   <= 1'b0;
                  rsp_valid[gsel] <= 1'b1;
                  drv_op          <= '0;
               end else begin
                  counter <= counter - CW'(1);
               end
            end
            DONE: begin
               if (rsp_ready[gsel]) begin
                  rsp_valid[gsel] <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

   assign bus.req0_ready = accept & ~grant_idx;
   assign bus.req1_ready = accept &  grant_idx;

   assign bus.alu_a  = drv_a;
   assign bus.alu_b  = drv_b;
   assign bus.alu_op = drv_op;
   assign bus.alu_cf = drv_cf;

   assign bus.rsp0_valid = rsp_valid[0];
   assign bus.rsp0_err   = rsp_err[0];
   assign bus.rsp0_cf    = rsp_cf[0];
   assign bus.rsp0_zf    = rsp_zf[0];
   assign bus.rsp0_of    = rsp_of[0];
   assign bus.rsp0_acc   = rsp_acc[0];
   assign bus.rsp0_c     = rsp_c[0];

   assign bus.rsp1_valid = rsp_valid[1];
   assign bus.rsp1_err   = rsp_err[1];
   assign bus.rsp1_cf    = rsp_cf[1];
   assign bus.rsp1_zf    = rsp_zf[1];
   assign bus.rsp1_of    = rsp_of[1];
   assign bus.rsp1_acc   = rsp_acc[1];
   assign bus.rsp1_c     = rsp_c[1];
endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
//==============================================================================
// tb_alu_arbiter: directed bench for alu_arbiter with a registered ALU stand-in
// Revision: 1.0
//==============================================================================
module tb_alu_arbiter;
   localparam int WIDTH    = 16;
   localparam int OPW      = 8;
   localparam int LAT      = 1;
   localparam int LAT_LONG = 3;

   logic clk = 1'b0;
   logic reset;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   alu_arbiter_if #(.WIDTH(WIDTH), .OPW(OPW)) bus ();

   alu_arbiter #(
      .WIDTH(WIDTH), .OPW(OPW), .LAT(LAT), .LAT_LONG(LAT_LONG)
   ) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   // Registered ALU stand-in: op 01 ADD, 02 SUB, 03 AND, 04 OR, 05-06 MUL,
   // 07-08 DIV, 09 XOR; anything else passes a. c is a for non-mul/div ops.
   logic [WIDTH:0]       m_sum;
   logic [2*WIDTH-1:0]   m_prod;
   logic [WIDTH-1:0]     m_acc, m_c;
   logic                 m_cf, m_of;

   always_comb begin
      m_sum  = '0;
      m_prod = '0;
      m_acc  = bus.alu_a;
      m_c    = bus.alu_a;
      m_cf   = 1'b0;
      m_of   = 1'b0;
      case (bus.alu_op)
         8'h01: begin
            m_sum = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {16'b0, bus.alu_cf};
            m_acc = m_sum[15:0];
            m_cf  = m_sum[16];
            m_of  = (bus.alu_a[15] == bus.alu_b[15]) && (m_sum[15] != bus.alu_a[15]);
         end
         8'h02: begin
            m_sum = {1'b0, bus.alu_a} - {1'b0, bus.alu_b} - {16'b0, bus.alu_cf};
            m_acc = m_sum[15:0];
            m_cf  = m_sum[16];
            m_of  = (bus.alu_a[15] != bus.alu_b[15]) && (m_sum[15] != bus.alu_a[15]);
         end
         8'h03: m_acc = bus.alu_a & bus.alu_b;
         8'h04: m_acc = bus.alu_a | bus.alu_b;
         8'h09: m_acc = bus.alu_a ^ bus.alu_b;
         8'h05, 8'h06: begin
            m_prod = {16'b0, bus.alu_a} * {16'b0, bus.alu_b};
            m_acc  = m_prod[15:0];
            m_c    = m_prod[31:16];
         end
         8'h07, 8'h08: begin
            if (bus.alu_b != 16'h0) begin
               m_acc = bus.alu_a / bus.alu_b;
               m_c   = bus.alu_a % bus.alu_b;
            end else begin
               m_acc = 16'hFFFF;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      bus.alu_acc    <= m_acc;
      bus.alu_c      <= m_c;
      bus.alu_c_flag <= m_cf;
      bus.alu_z_flag <= (m_acc == 16'h0);
      bus.alu_o_flag <= m_of;
   end

   // {valid, err, cf, zf, of, acc, c}
   function automatic logic [36:0] rsp(input bit port);
      if (port)
         return {bus.rsp1_valid, bus.rsp1_err, bus.rsp1_cf, bus.rsp1_zf, bus.rsp1_of, bus.rsp1_acc, bus.rsp1_c};
      return {bus.rsp0_valid, bus.rsp0_err, bus.rsp0_cf, bus.rsp0_zf, bus.rsp0_of, bus.rsp0_acc, bus.rsp0_c};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input bit port, input logic [15:0] a, input logic [15:0] b,
                          input logic [7:0] op, input logic cf);
      if (port) begin
         bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_cf = cf;
      end else begin
         bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_cf = cf;
      end
   endtask

   task automatic do_reset();
      reset = 1'b0;
      step();
      #2 reset = 1'b1;
      step();
   endtask

   task automatic test_reset();
      bit seen;
      step();
      checks++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cf} !== 41'h0) begin
         errors++; $display("FAIL reset_alu: got %h expected 0", {bus.alu_op, bus.alu_a, bus.alu_b, bus.alu_cf});
      end
      checks++;
      if ({rsp(1), rsp(0)} !== 74'h0) begin
         errors++; $display("FAIL reset_rsp: got %h expected 0", {rsp(1), rsp(0)});
      end
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
         errors++; $display("FAIL reset_grant: got %b expected 01", {bus.req1_ready, bus.req0_ready});
      end
      bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
      step();
      #2 reset = 1'b1;
      step();
      // Complete one ADD so the response registers hold nonzero data.
      bus.rsp0_ready = 1'b1;
      set_req(0, 16'h0003, 16'h0004, 8'h01, 1'b0);
      bus.req0_valid = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      step(); step(); step();
      set_req(0, 16'h0001, 16'h0001, 8'h01, 1'b0);
      bus.req0_valid = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      #2 reset = 1'b0;
      #1;
      checks++;
      if ({bus.alu_op, bus.alu_a, bus.alu_b} !== 40'h0) begin
         errors++; $display("FAIL reset_async_alu: got %h expected 0", {bus.alu_op, bus.alu_a, bus.alu_b});
      end
      checks++;
      if (rsp(0) !== 37'h0) begin
         errors++; $display("FAIL reset_async_rsp: got %h expected 0", rsp(0));
      end
      step();
      #2 reset = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         if (bus.rsp0_valid !== 1'b0) seen = 1'b1;
      end
      checks++;
      if (seen !== 1'b0) begin
         errors++; $display("FAIL reset_no_rsp: got rsp0_valid=1 expected 0");
      end
      set_req(1, 16'h0000, 16'h0000, 8'h01, 1'b0);
      bus.req1_valid = 1'b1;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         errors++; $display("FAIL reset_idle: got %b expected 10", {bus.req1_ready, bus.req0_ready});
      end
      bus.req1_valid = 1'b0;
   endtask

   task automatic test_add();
      step();
      bus.rsp0_ready = 1'b1;
      set_req(0, 16'h0003, 16'h0004, 8'h01, 1'b0);
      bus.req0_valid = 1'b1;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
         errors++; $display("FAIL add_ready: got %b expected 01", {bus.req1_ready, bus.req0_ready});
      end
      step();
      bus.req0_valid = 1'b0;
      checks++;
      if ({bus.req0_ready, bus.alu_op, bus.alu_a, bus.alu_b} !== {1'b0, 8'h01, 16'h0003, 16'h0004}) begin
         errors++; $display("FAIL add_issue: got %h expected %h", {bus.req0_ready, bus.alu_op, bus.alu_a, bus.alu_b},
                            {1'b0, 8'h01, 16'h0003, 16'h0004});
      end
      step();
      checks++;
      if (bus.rsp0_valid !== 1'b0) begin
         errors++; $display("FAIL add_latency: got rsp0_valid=%b expected 0", bus.rsp0_valid);
      end
      step();
      checks++;
      if (rsp(0) !== {5'b10000, 16'h0007, 16'h0003}) begin
         errors++; $display("FAIL add_rsp: got %h expected %h", rsp(0), {5'b10000, 16'h0007, 16'h0003});
      end
      checks++;
      if (bus.alu_op !== 8'h00) begin
         errors++; $display("FAIL add_alu_idle: got %h expected 00", bus.alu_op);
      end
      step();
      checks++;
      if (rsp(0) !== {5'b00000, 16'h0007, 16'h0003}) begin
         errors++; $display("FAIL add_release: got %h expected %h", rsp(0), {5'b00000, 16'h0007, 16'h0003});
      end
      // 0x7FFF + 0 + carry-in: signed overflow, no carry out.
      set_req(0, 16'h7FFF, 16'h0000, 8'h01, 1'b1);
      bus.req0_valid = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      step(); step();
      checks++;
      if (rsp(0) !== {5'b10001, 16'h8000, 16'h7FFF}) begin
         errors++; $display("FAIL add_cin_ovf: got %h expected %h", rsp(0), {5'b10001, 16'h8000, 16'h7FFF});
      end
      step();
      set_req(0, 16'hFFFF, 16'h0001, 8'h01, 1'b0);
      bus.req0_valid = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      step(); step();
      checks++;
      if (rsp(0) !== {5'b10110, 16'h0000, 16'hFFFF}) begin
         errors++; $display("FAIL add_carry: got %h expected %h", rsp(0), {5'b10110, 16'h0000, 16'hFFFF});
      end
      step();
   endtask

   task automatic test_round_robin();
      do_reset();
      bus.rsp0_ready = 1'b1; bus.rsp1_ready = 1'b1;
      set_req(0, 16'h0005, 16'h0005, 8'h02, 1'b0);
      set_req(1, 16'hFFFF, 16'h00FF, 8'h09, 1'b0);
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
         errors++; $display("FAIL rr_first: got %b expected 01", {bus.req1_ready, bus.req0_ready});
      end
      step();
      bus.req0_valid = 1'b0;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b00) begin
         errors++; $display("FAIL rr_busy: got %b expected 00", {bus.req1_ready, bus.req0_ready});
      end
      step(); step();
      checks++;
      if (rsp(0) !== {5'b10010, 16'h0000, 16'h0005}) begin
         errors++; $display("FAIL rr_rsp0: got %h expected %h", rsp(0), {5'b10010, 16'h0000, 16'h0005});
      end
      step();
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         errors++; $display("FAIL rr_second: got %b expected 10", {bus.req1_ready, bus.req0_ready});
      end
      step();
      bus.req1_valid = 1'b0;
      step(); step();
      checks++;
      if (rsp(1) !== {5'b10000, 16'hFF00, 16'hFFFF}) begin
         errors++; $display("FAIL rr_rsp1: got %h expected %h", rsp(1), {5'b10000, 16'hFF00, 16'hFFFF});
      end
      step();
      // Second simultaneous pair; port 0 re-requests straight away to force a tie.
      set_req(0, 16'h0002, 16'h0001, 8'h02, 1'b0);
      set_req(1, 16'h00F0, 16'h0F0F, 8'h04, 1'b0);
      bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
      #1;
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
         errors++; $display("FAIL rr_pair2_first: got %b expected 01", {bus.req1_ready, bus.req0_ready});
      end
      step();
      set_req(0, 16'h0010, 16'h0020, 8'h01, 1'b0);
      step(); step();
      checks++;
      if (rsp(0) !== {5'b10000, 16'h0001, 16'h0002}) begin
         errors++; $display("FAIL rr_pair2_rsp0: got %h expected %h", rsp(0), {5'b10000, 16'h0001, 16'h0002});
      end
      step();
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         errors++; $display("FAIL rr_alternate: got %b expected 10", {bus.req1_ready, bus.req0_ready});
      end
      step();
      bus.req1_valid = 1'b0;
      step(); step();
      checks++;
      if (rsp(1) !== {5'b10000, 16'h0FFF, 16'h00F0}) begin
         errors++; $display("FAIL rr_pair2_rsp1: got %h expected %h", rsp(1), {5'b10000, 16'h0FFF, 16'h00F0});
      end
      step();
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b01) begin
         errors++; $display("FAIL rr_third: got %b expected 01", {bus.req1_ready, bus.req0_ready});
      end
      step();
      bus.req0_valid = 1'b0;
      step(); step();
      checks++;
      if (rsp(0) !== {5'b10000, 16'h0030, 16'h0010}) begin
         errors++; $display("FAIL rr_rsp0_add: got %h expected %h", rsp(0), {5'b10000, 16'h0030, 16'h0010});
      end
      step();
   endtask

   task automatic test_illegal();
      step();
      bus.rsp1_ready = 1'b0;
      set_req(1, 16'h1234, 16'h5678, 8'h20, 1'b1);
      bus.req1_valid = 1'b1;
      #1;
      checks++;
      if ({bus.req1_ready, bus.alu_op} !== {1'b1, 8'h00}) begin
         errors++; $display("FAIL ill_ready: got %h expected %h", {bus.req1_ready, bus.alu_op}, {1'b1, 8'h00});
      end
      step();
      bus.req1_valid = 1'b0;
      checks++;
      if (rsp(1) !== {5'b11000, 16'h0000, 16'h0000}) begin
         errors++; $display("FAIL ill_rsp: got %h expected %h", rsp(1), {5'b11000, 16'h0000, 16'h0000});
      end
      checks++;
      if ({bus.alu_op, bus.alu_a} !== {8'h00, 16'h0010}) begin
         errors++; $display("FAIL ill_alu_untouched: got %h expected %h", {bus.alu_op, bus.alu_a}, {8'h00, 16'h0010});
      end
      step();
      checks++;
      if (rsp(1) !== {5'b11000, 16'h0000, 16'h0000}) begin
         errors++; $display("FAIL ill_hold: got %h expected %h", rsp(1), {5'b11000, 16'h0000, 16'h0000});
      end
      bus.rsp1_ready = 1'b1;
      step();
      checks++;
      if (rsp(1) !== {5'b01000, 16'h0000, 16'h0000}) begin
         errors++; $display("FAIL ill_release: got %h expected %h", rsp(1), {5'b01000, 16'h0000, 16'h0000});
      end
      bus.rsp0_ready = 1'b1;
      set_req(0, 16'h0007, 16'h0007, 8'h00, 1'b0);
      bus.req0_valid = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      checks++;
      if (rsp(0) !== {5'b11000, 16'h0000, 16'h0000}) begin
         errors++; $display("FAIL ill_op00: got %h expected %h", rsp(0), {5'b11000, 16'h0000, 16'h0000});
      end
      step();
      set_req(0, 16'h0007, 16'h0007, 8'h12, 1'b0);
      bus.req0_valid = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      checks++;
      if (rsp(0) !== {5'b11000, 16'h0000, 16'h0000}) begin
         errors++; $display("FAIL ill_op12: got %h expected %h", rsp(0), {5'b11000, 16'h0000, 16'h0000});
      end
      step();
      set_req(0, 16'hABCD, 16'h0001, 8'h11, 1'b0);
      bus.req0_valid = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      checks++;
      if (bus.alu_op !== 8'h11) begin
         errors++; $display("FAIL legal_op11_issue: got %h expected 11", bus.alu_op);
      end
      step(); step();
      checks++;
      if (rsp(0) !== {5'b10000, 16'hABCD, 16'hABCD}) begin
         errors++; $display("FAIL legal_op11_rsp: got %h expected %h", rsp(0), {5'b10000, 16'hABCD, 16'hABCD});
      end
      step();
   endtask

   task automatic test_long_hold();
      bit early, bad_hold, bad_grant;
      step();
      bus.rsp0_ready = 1'b0; bus.rsp1_ready = 1'b1;
      set_req(0, 16'h0100, 16'h0100, 8'h06, 1'b0);
      bus.req0_valid = 1'b1;
      step();
      bus.req0_valid = 1'b0;
      set_req(1, 16'hF0F0, 16'h0FF0, 8'h03, 1'b0);
      bus.req1_valid = 1'b1;
      checks++;
      if (bus.alu_op !== 8'h06) begin
         errors++; $display("FAIL long_issue: got %h expected 06", bus.alu_op);
      end
      early = 1'b0; bad_grant = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.rsp0_valid !== 1'b0) early = 1'b1;
         if (bus.req1_ready !== 1'b0) bad_grant = 1'b1;
      end
      checks++;
      if (early !== 1'b0) begin
         errors++; $display("FAIL long_latency: got rsp0_valid=1 before E0+4 expected 0");
      end
      step();
      checks++;
      if (rsp(0) !== {5'b10010, 16'h0000, 16'h0001}) begin
         errors++; $display("FAIL long_rsp: got %h expected %h", rsp(0), {5'b10010, 16'h0000, 16'h0001});
      end
      bad_hold = 1'b0;
      for (int i = 0; i < 5; i++) begin
         step();
         if (rsp(0) !== {5'b10010, 16'h0000, 16'h0001}) bad_hold = 1'b1;
         if (bus.req1_ready !== 1'b0) bad_grant = 1'b1;
      end
      checks++;
      if (bad_hold !== 1'b0) begin
         errors++; $display("FAIL long_hold: got rsp0 changed while held, last %h", rsp(0));
      end
      checks++;
      if (bad_grant !== 1'b0) begin
         errors++; $display("FAIL long_no_grant: got req1_ready=1 before handshake expected 0");
      end
      bus.rsp0_ready = 1'b1;
      step();
      checks++;
      if (rsp(0) !== {5'b00010, 16'h0000, 16'h0001}) begin
         errors++; $display("FAIL long_release: got %h expected %h", rsp(0), {5'b00010, 16'h0000, 16'h0001});
      end
      checks++;
      if ({bus.req1_ready, bus.req0_ready} !== 2'b10) begin
         errors++; $display("FAIL long_then_req1: got %b expected 10", {bus.req1_ready, bus.req0_ready});
      end
      step();
      bus.req1_valid = 1'b0;
      step(); step();
      checks++;
      if (rsp(1) !== {5'b10000, 16'h00F0, 16'hF0F0}) begin
         errors++; $display("FAIL long_req1_rsp: got %h expected %h", rsp(1), {5'b10000, 16'h00F0, 16'hF0F0});
      end
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      reset          = 1'b0;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      bus.rsp0_ready = 1'b0;
      bus.rsp1_ready = 1'b0;
      set_req(0, 16'h0, 16'h0, 8'h0, 1'b0);
      set_req(1, 16'h0, 16'h0, 8'h0, 1'b0);
      test_reset();
      test_add();
      test_round_robin();
      test_illegal();
      test_long_hold();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire
